// File: rtl/w_grf_writer.sv
// w_grf_writer: arbitrates W-stage and queued MDU writes onto the single GRF write port
module w_grf_writer #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_a3,
  input  logic [31:0]   pipe_wd,
  input  logic [31:0]   pipe_pc,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_a3,
  input  logic [31:0]   mdu_wd,
  input  logic [31:0]   mdu_pc,
  input  logic [4:0]    rd_a1,
  input  logic [4:0]    rd_a2,
  output logic          busy_a1,
  output logic          busy_a2,
  output logic          grf_we,
  output logic [4:0]    grf_a3,
  output logic [31:0]   grf_wd,
  output logic [31:0]   grf_pc,
  output logic [AW:0]   q_count
);
  logic [DEPTH-1:0] q_live;
  logic [4:0]       q_a3 [DEPTH];
  logic [31:0]      q_wd [DEPTH];
  logic [31:0]      q_pc [DEPTH];
  logic [AW-1:0]    head, tail;
  logic pipe_eff, mdu_ok, empty, pop, bypass, enq;
  assign mdu_ready = q_count < (AW+1)'(DEPTH);
  assign pipe_eff = pipe_we && pipe_a3 != 5'd0;
  // a same-cycle pipe write to the same register makes the older MDU result dead
  assign mdu_ok = mdu_valid && mdu_ready && mdu_a3 != 5'd0 && !(pipe_eff && mdu_a3 == pipe_a3);
  assign empty = q_count == '0;
  assign pop = !pipe_eff && !empty;
  assign bypass = !pipe_eff && empty && mdu_ok;
  assign enq = mdu_ok && !bypass;
  always_comb begin
    busy_a1 = 1'b0;
    busy_a2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_a1 = busy_a1 | (q_live[i] && q_a3[i] == rd_a1);
      busy_a2 = busy_a2 | (q_live[i] && q_a3[i] == rd_a2);
    end
    busy_a1 = busy_a1 && rd_a1 != 5'd0;
    busy_a2 = busy_a2 && rd_a2 != 5'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grf_we <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
      q_live <= '0;
      head <= '0;
      tail <= '0;
      q_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_a3[i] <= '0;
        q_wd[i] <= '0;
        q_pc[i] <= '0;
      end
    end else begin
      grf_we <= pipe_eff || bypass || (pop && q_live[head]);
      if (pipe_eff) begin
        grf_a3 <= pipe_a3;
        grf_wd <= pipe_wd;
        grf_pc <= pipe_pc;
      end else if (pop && q_live[head]) begin
        grf_a3 <= q_a3[head];
        grf_wd <= q_wd[head];
        grf_pc <= q_pc[head];
      end else if (bypass) begin
        grf_a3 <= mdu_a3;
        grf_wd <= mdu_wd;
        grf_pc <= mdu_pc;
      end
      for (int i = 0; i < DEPTH; i++)
        if (pipe_eff && q_a3[i] == pipe_a3) q_live[i] <= 1'b0;
      if (pop) begin
        q_live[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (enq) begin
        q_live[tail] <= 1'b1;
        q_a3[tail] <= mdu_a3;
        q_wd[tail] <= mdu_wd;
        q_pc[tail] <= mdu_pc;
        tail <= tail + 1'b1;
      end
      q_count <= q_count + (AW+1)'(enq) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_w_grf_writer.sv
// tb_w_grf_writer: directed checks of pipe priority, MDU bypass/queue, kill and async reset
module tb_w_grf_writer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic pipe_we = 1'b0, mdu_valid = 1'b0;
  logic [4:0] pipe_a3 = '0, mdu_a3 = '0, rd_a1 = '0, rd_a2 = '0;
  logic [31:0] pipe_wd = '0, pipe_pc = '0, mdu_wd = '0, mdu_pc = '0;
  logic mdu_ready, busy_a1, busy_a2, grf_we;
  logic [4:0] grf_a3;
  logic [31:0] grf_wd, grf_pc;
  logic [2:0] q_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  w_grf_writer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .busy_a1(busy_a1), .busy_a2(busy_a2),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc), .q_count(q_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    pipe_we = we; pipe_a3 = a3; pipe_wd = wd; pipe_pc = pc;
  endtask
  task automatic mdu(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    mdu_valid = v; mdu_a3 = a3; mdu_wd = wd; mdu_pc = pc;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_we", grf_we, 0);
    chk("rst_a3", grf_a3, 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_pc", grf_pc, 0);
    chk("rst_cnt", q_count, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_busy1", busy_a1, 0);
    chk("rst_busy2", busy_a2, 0);
    step();
    rst_n = 1'b1;
    // plain pipe write
    pipe(1, 5, 32'h1234, 32'h3000);
    step();
    chk("pipe_we", grf_we, 1);
    chk("pipe_a3", grf_a3, 5);
    chk("pipe_wd", grf_wd, 32'h1234);
    chk("pipe_pc", grf_pc, 32'h3000);
    pipe(0, 0, 0, 0);
    step();
    chk("pipe_we_off", grf_we, 0);
    chk("pipe_hold_a3", grf_a3, 5);
    // MDU bypass with empty queue
    mdu(1, 8, 32'hAA, 32'h4000);
    #1 chk("byp_ready", mdu_ready, 1);
    step();
    mdu(0, 0, 0, 0);
    chk("byp_we", grf_we, 1);
    chk("byp_a3", grf_a3, 8);
    chk("byp_wd", grf_wd, 32'hAA);
    chk("byp_cnt", q_count, 0);
    // fill queue under back-to-back pipe writes
    for (int k = 0; k < 4; k++) begin
      pipe(1, 5'(20 + k), 32'h200 + k, 32'h6000);
      mdu(1, 5'(k + 1), 32'h100 + k, 32'h7000 + k);
      step();
    end
    pipe(0, 0, 0, 0);
    mdu(0, 0, 0, 0);
    chk("fill_a3", grf_a3, 23);
    chk("fill_cnt", q_count, 4);
    chk("fill_ready", mdu_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_we", grf_we, 1);
      chk("drain_a3", grf_a3, k + 1);
      chk("drain_wd", grf_wd, 32'h100 + k);
      chk("drain_cnt", q_count, 3 - k);
      chk("drain_ready", mdu_ready, 1);
    end
    step();
    chk("drain_idle", grf_we, 0);
    // kill a queued entry
    pipe(1, 10, 32'hA00, 32'h5000);
    mdu(1, 9, 32'h99, 32'h5100);
    step();
    mdu(0, 0, 0, 0);
    rd_a1 = 9; rd_a2 = 7;
    chk("kill_cnt0", q_count, 1);
    pipe(1, 9, 32'h900, 32'h5200);
    #1;
    chk("kill_busy1", busy_a1, 1);
    chk("kill_busy2", busy_a2, 0);
    step();
    pipe(0, 0, 0, 0);
    chk("kill_busy_after", busy_a1, 0);
    chk("kill_a3", grf_a3, 9);
    chk("kill_wd", grf_wd, 32'h900);
    chk("kill_cnt1", q_count, 1);
    step();
    chk("kill_pop_we", grf_we, 0);
    chk("kill_pop_wd", grf_wd, 32'h900);
    chk("kill_pop_cnt", q_count, 0);
    rd_a1 = 0; rd_a2 = 0;
    // same-cycle MDU to the register the pipe writes is dropped
    pipe(1, 14, 32'hE00, 32'h5300);
    mdu(1, 14, 32'hE1, 32'h5310);
    step();
    pipe(0, 0, 0, 0);
    mdu(0, 0, 0, 0);
    chk("same_wd", grf_wd, 32'hE00);
    chk("same_cnt", q_count, 0);
    step();
    chk("same_idle", grf_we, 0);
    // MDU completion to r0 is discarded
    mdu(1, 0, 32'h55, 32'h5400);
    step();
    mdu(0, 0, 0, 0);
    chk("r0_mdu_we", grf_we, 0);
    chk("r0_mdu_cnt", q_count, 0);
    // pipe write to r0 lets the queue drain
    pipe(1, 11, 32'hB00, 32'h5500);
    mdu(1, 12, 32'h120, 32'h5600);
    step();
    mdu(0, 0, 0, 0);
    chk("r0_pipe_cnt0", q_count, 1);
    pipe(1, 0, 32'hDEAD, 32'h5700);
    step();
    pipe(0, 0, 0, 0);
    chk("r0_pipe_we", grf_we, 1);
    chk("r0_pipe_a3", grf_a3, 12);
    chk("r0_pipe_wd", grf_wd, 32'h120);
    chk("r0_pipe_cnt", q_count, 0);
    // async reset with three queued entries
    for (int k = 0; k < 3; k++) begin
      pipe(1, 5'(13 + k), 32'hC00 + k, 32'h5800);
      mdu(1, 5'(16 + k), 32'h160 + k, 32'h5900);
      step();
    end
    chk("ar_cnt0", q_count, 3);
    chk("ar_we0", grf_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_we", grf_we, 0);
    chk("ar_cnt", q_count, 0);
    chk("ar_ready", mdu_ready, 1);
    chk("ar_wd", grf_wd, 0);
    pipe(0, 0, 0, 0);
    mdu(0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_post_we", grf_we, 0);
    chk("ar_post_cnt", q_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
